// File: rtl/rs_latch_ctrl.sv
// Sequencer owning the S/R inputs of a cross-coupled RS latch: arbitrates set/clear
// requests, emits non-overlapping fixed-width pulses, then checks Q/Qn feedback.
module rs_latch_ctrl #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic fault_clr,
  input  logic Q,
  input  logic Qn,
  output logic S,
  output logic R,
  output logic busy,
  output logic ack,
  output logic mismatch,
  output logic exp_q,
  output logic fault
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_PULSE,
    ST_GAP,
    ST_CHECK
  } state_t;

  localparam logic [CNT_W-1:0] LP_PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] LP_GAP_LD   = CNT_W'(GAP_W - 1);

  state_t           r_state, w_nxt_state;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic             r_exp_q, w_nxt_exp_q;
  logic             r_prio, w_nxt_prio;
  logic             r_init_op, w_nxt_init_op;
  logic             r_fault, w_nxt_fault;
  logic             r_s, r_r;
  logic             w_check_fail;
  logic             w_accept;

  assign w_check_fail = (Q != r_exp_q) || (Q == Qn);

  // State register; S/R are registered from the next state so they are glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_INIT;
      r_cnt     <= '0;
      r_exp_q   <= 1'b0;
      r_prio    <= 1'b0;
      r_init_op <= 1'b1;
      r_fault   <= 1'b0;
      r_s       <= 1'b0;
      r_r       <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_exp_q   <= w_nxt_exp_q;
      r_prio    <= w_nxt_prio;
      r_init_op <= w_nxt_init_op;
      r_fault   <= w_nxt_fault;
      r_s       <= (w_nxt_state == ST_PULSE) &&  w_nxt_exp_q;
      r_r       <= (w_nxt_state == ST_PULSE) && !w_nxt_exp_q;
    end
  end

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_cnt     = r_cnt;
    w_nxt_exp_q   = r_exp_q;
    w_nxt_prio    = r_prio;
    w_nxt_init_op = r_init_op;
    w_accept      = 1'b0;

    // A failing check overrides a coincident fault_clr
    w_nxt_fault = r_fault;
    if (fault_clr)
      w_nxt_fault = 1'b0;
    if ((r_state == ST_CHECK) && w_check_fail)
      w_nxt_fault = 1'b1;

    case (r_state)
      ST_INIT: begin
        w_nxt_state   = ST_PULSE;
        w_nxt_cnt     = LP_PULSE_LD;
        w_nxt_exp_q   = 1'b0;
        w_nxt_init_op = 1'b1;
      end
      ST_IDLE: begin
        if (set_req && clr_req) begin
          w_accept    = 1'b1;
          w_nxt_exp_q = ~r_prio;
          w_nxt_prio  = ~r_prio;
        end else if (set_req) begin
          w_accept    = 1'b1;
          w_nxt_exp_q = 1'b1;
        end else if (clr_req) begin
          w_accept    = 1'b1;
          w_nxt_exp_q = 1'b0;
        end
        if (w_accept) begin
          w_nxt_state   = ST_PULSE;
          w_nxt_cnt     = LP_PULSE_LD;
          w_nxt_init_op = 1'b0;
        end
      end
      ST_PULSE: begin
        if (r_cnt == '0) begin
          w_nxt_state = ST_GAP;
          w_nxt_cnt   = LP_GAP_LD;
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == '0)
          w_nxt_state = ST_CHECK;
        else
          w_nxt_cnt = r_cnt - 1'b1;
      end
      ST_CHECK: begin
        w_nxt_state = ST_IDLE;
      end
      default: begin
        w_nxt_state = ST_INIT;
      end
    endcase
  end

  always_comb begin
    S        = r_s;
    R        = r_r;
    busy     = (r_state != ST_IDLE);
    ack      = (r_state == ST_CHECK) && !r_init_op;
    mismatch = (r_state == ST_CHECK) && !r_init_op && w_check_fail;
    exp_q    = r_exp_q;
    fault    = r_fault;
  end

endmodule

// File: tb/tb_rs_latch_ctrl.sv
// Directed bench for rs_latch_ctrl driving a behavioural RS latch with fault injection.
module tb_rs_latch_ctrl;

  logic clk = 1'b0;
  logic rst, set_req, clr_req, fault_clr;
  logic Q, Qn, S, R, busy, ack, mismatch, exp_q, fault;

  logic lq = 1'b1;
  logic inj_en = 1'b0, inj_q = 1'b0, inj_qn = 1'b0;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int stray = 0;

  rs_latch_ctrl #(.PULSE_W(4), .GAP_W(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
    .fault_clr(fault_clr), .Q(Q), .Qn(Qn), .S(S), .R(R), .busy(busy),
    .ack(ack), .mismatch(mismatch), .exp_q(exp_q), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(S or R) begin
    if (S && !R) lq = 1'b1;
    else if (R && !S) lq = 1'b0;
  end

  assign Q  = inj_en ? inj_q  : lq;
  assign Qn = inj_en ? inj_qn : ~lq;

  always @(negedge clk) begin
    if (!rst) begin
      if (S && R) overlap++;
      if ((ack || mismatch) && !busy) stray++;
      if (mismatch && !ack) stray++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: drop requests after acceptance, 1: hold them, 2: drop set and toggle clr
  task automatic run_op(input int mode, input int max_c, output int n_s, output int n_r,
                        output int n_busy, output int ack_c, output logic mm, output logic eq);
    n_s = 0; n_r = 0; n_busy = 0; ack_c = 0; mm = 1'b0; eq = 1'b0;
    for (int c = 1; c <= max_c; c++) begin
      step();
      if (c == 1 && mode != 1) begin
        set_req = 1'b0;
        if (mode == 0) clr_req = 1'b0;
      end
      if (mode == 2) clr_req = ~clr_req;
      if (S) n_s++;
      if (R) n_r++;
      if (busy) n_busy++;
      if (ack) begin
        ack_c = c; mm = mismatch; eq = exp_q;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n_s, n_r, n_b, a;
    logic mm, eq;
    rst = 1'b1; set_req = 1'b0; clr_req = 1'b0; fault_clr = 1'b0;
    step(); step();
    checks++; if ({S, R, busy, ack, mismatch, exp_q, fault} !== 7'b0010000) begin
      errors++; $display("FAIL reset_state got %b want 0010000", {S, R, busy, ack, mismatch, exp_q, fault});
    end
    rst = 1'b0;
    run_op(0, 8, n_s, n_r, n_b, a, mm, eq);
    checks++; if (n_r !== 4) begin errors++; $display("FAIL init_r_width got %0d want 4", n_r); end
    checks++; if (n_s !== 0) begin errors++; $display("FAIL init_s_width got %0d want 0", n_s); end
    checks++; if (n_b !== 7) begin errors++; $display("FAIL init_busy got %0d want 7", n_b); end
    checks++; if (a !== 0) begin errors++; $display("FAIL init_no_ack got %0d want 0", a); end
    checks++; if ({busy, exp_q, fault, Q} !== 4'b0000) begin
      errors++; $display("FAIL init_end got %b want 0000", {busy, exp_q, fault, Q});
    end
  endtask

  task automatic test_set_clear();
    int n_s, n_r, n_b, a;
    logic mm, eq;
    set_req = 1'b1;
    run_op(0, 12, n_s, n_r, n_b, a, mm, eq);
    checks++; if ({n_s, n_r} !== {32'd4, 32'd0}) begin errors++; $display("FAIL set_pulse got S=%0d R=%0d want 4/0", n_s, n_r); end
    checks++; if (a !== 7) begin errors++; $display("FAIL set_latency got %0d want 7", a); end
    checks++; if (n_b !== 7) begin errors++; $display("FAIL set_busy got %0d want 7", n_b); end
    checks++; if ({mm, eq, Q} !== 3'b011) begin errors++; $display("FAIL set_result got %b want 011", {mm, eq, Q}); end
    step();
    checks++; if ({busy, ack} !== 2'b00) begin errors++; $display("FAIL set_idle got %b want 00", {busy, ack}); end
    clr_req = 1'b1;
    run_op(0, 12, n_s, n_r, n_b, a, mm, eq);
    checks++; if ({n_s, n_r} !== {32'd0, 32'd4}) begin errors++; $display("FAIL clr_pulse got S=%0d R=%0d want 0/4", n_s, n_r); end
    checks++; if (a !== 7) begin errors++; $display("FAIL clr_latency got %0d want 7", a); end
    checks++; if ({mm, eq, Q} !== 3'b000) begin errors++; $display("FAIL clr_result got %b want 000", {mm, eq, Q}); end
    step();
  endtask

  task automatic test_back_to_back();
    int n_s, n_r, n_b, a;
    logic mm, eq;
    logic [2:0] want;
    want = 3'b101;
    set_req = 1'b1; clr_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_op(1, 12, n_s, n_r, n_b, a, mm, eq);
      checks++; if (eq !== want[2-k]) begin errors++; $display("FAIL tie_side op%0d got %b want %b", k, eq, want[2-k]); end
      checks++; if (a !== 7 || (n_s + n_r) !== 4 || (want[2-k] ? n_s : n_r) !== 4) begin
        errors++; $display("FAIL tie_pulse op%0d got ack=%0d S=%0d R=%0d", k, a, n_s, n_r);
      end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tie_idle_gap op%0d got busy=%b want 0", k, busy); end
    end
    set_req = 1'b0; clr_req = 1'b0;
    step();
  endtask

  task automatic test_fault();
    int n_s, n_r, n_b, a;
    logic mm, eq;
    inj_en = 1'b1; inj_q = 1'b0; inj_qn = 1'b1;
    set_req = 1'b1;
    run_op(0, 12, n_s, n_r, n_b, a, mm, eq);
    checks++; if ({a == 7, mm} !== 2'b11) begin errors++; $display("FAIL stuck_mismatch got ack=%0d mm=%b want 7/1", a, mm); end
    step();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL stuck_fault got %b want 1", fault); end
    step();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got %b want 1", fault); end
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clr got %b want 0", fault); end
    set_req = 1'b1;
    run_op(0, 12, n_s, n_r, n_b, a, mm, eq);
    checks++; if (mm !== 1'b1) begin errors++; $display("FAIL stuck_mismatch2 got %b want 1", mm); end
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_set_wins got %b want 1", fault); end
    inj_en = 1'b0;
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
  endtask

  task automatic test_ignore_and_reset();
    int n_s, n_r, n_b, a;
    logic mm, eq;
    set_req = 1'b1;
    run_op(2, 12, n_s, n_r, n_b, a, mm, eq);
    checks++; if ({n_s, n_r} !== {32'd4, 32'd0} || eq !== 1'b1 || a !== 7) begin
      errors++; $display("FAIL ignore_clr got S=%0d R=%0d eq=%b ack=%0d want 4/0/1/7", n_s, n_r, eq, a);
    end
    clr_req = 1'b0;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_op got busy=%b want 0", busy); end
    // reset while S is high in PULSE
    clr_req = 1'b1;
    step(); clr_req = 1'b0; set_req = 1'b1;
    step(); step(); step(); step(); set_req = 1'b0;
    step(); step(); step();
    set_req = 1'b1; step(); set_req = 1'b0; step();
    checks++; if (S !== 1'b1) begin errors++; $display("FAIL pre_reset_s got %b want 1", S); end
    #2 rst = 1'b1; #1;
    checks++; if ({S, R, busy, exp_q} !== 4'b0010) begin errors++; $display("FAIL pulse_reset got %b want 0010", {S, R, busy, exp_q}); end
    rst = 1'b0;
    run_op(0, 8, n_s, n_r, n_b, a, mm, eq);
    checks++; if (n_r !== 4 || n_b !== 7 || a !== 0) begin
      errors++; $display("FAIL pulse_reinit got R=%0d busy=%0d ack=%0d want 4/7/0", n_r, n_b, a);
    end
    // reset while in GAP
    set_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin step(); set_req = 1'b0; end
    checks++; if ({S, R, busy} !== 3'b001) begin errors++; $display("FAIL gap_state got %b want 001", {S, R, busy}); end
    #2 rst = 1'b1; #1;
    checks++; if ({S, R, busy, ack, exp_q, fault} !== 6'b001000) begin
      errors++; $display("FAIL gap_reset got %b want 001000", {S, R, busy, ack, exp_q, fault});
    end
    rst = 1'b0;
    run_op(0, 8, n_s, n_r, n_b, a, mm, eq);
    checks++; if (n_r !== 4 || n_s !== 0 || n_b !== 7 || a !== 0) begin
      errors++; $display("FAIL gap_reinit got S=%0d R=%0d busy=%0d ack=%0d", n_s, n_r, n_b, a);
    end
    checks++; if ({Q, exp_q, busy} !== 3'b000) begin errors++; $display("FAIL gap_reinit_end got %b want 000", {Q, exp_q, busy}); end
  endtask

  task automatic test_q_eq_qn();
    int n_s, n_r, n_b, a;
    logic mm, eq;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL qn_pre_fault got %b want 0", fault); end
    inj_en = 1'b1; inj_q = 1'b1; inj_qn = 1'b1;
    set_req = 1'b1;
    run_op(0, 12, n_s, n_r, n_b, a, mm, eq);
    checks++; if ({a == 7, eq, mm} !== 3'b111) begin errors++; $display("FAIL qn_mismatch got ack=%0d eq=%b mm=%b want 7/1/1", a, eq, mm); end
    step();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL qn_fault got %b want 1", fault); end
    inj_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_set_clear();
    test_back_to_back();
    test_fault();
    test_ignore_and_reset();
    test_q_eq_qn();
    checks++; if (overlap !== 0) begin errors++; $display("FAIL sr_overlap got %0d want 0", overlap); end
    checks++; if (stray !== 0) begin errors++; $display("FAIL ack_outside_check got %0d want 0", stray); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
